rom_arbiter: RTL and testbench
==============================

# rom_arbiter

Two-port arbiter that shares the single-port, synchronous-read instruction ROM between two read masters: master 0 (instruction fetch) and master 1 (data-bus read/loader). It sits directly in front of the ROM: it drives the ROM address, tracks which master owns each in-flight read, and returns registered read data with a ready strobe. It sustains one ROM read per cycle with round-robin or fixed-priority arbitration.

## Interface
- ADDR_W, 11, ROM word-address width; matches the ROM address bus.
- DATA_W, 32, ROM word width; matches the word data bus.
- ROUND_ROBIN, 1, 1 = round-robin on contention; 0 = master 0 always wins.

- clk  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- m0_req  input  1  master 0 read request; held until granted.
- m0_addr  input  ADDR_W  master 0 word address; stable while m0_req=1 and not granted.
- m0_gnt  output  1  master 0 request accepted this cycle (combinational).
- m0_rdy  output  1  master 0 read data valid (registered, 1-cycle pulse per grant).
- m0_rd_data  output  DATA_W  master 0 read data; holds last value between rdy pulses.
- m1_req, m1_addr, m1_gnt, m1_rdy, m1_rd_data: identical to the m0_* signals, for master 1.
- rom_addr  output  ADDR_W  address to ROM; ROM registers its output on the next edge.
- rom_dout  input  DATA_W  ROM read data, valid the cycle after rom_addr is sampled.

## Operation
- Arbitration (combinational, cycle N): winner = only requester if one; on contention, ROUND_ROBIN=1 picks the master indicated by prio_q, ROUND_ROBIN=0 picks master 0.
- The winner's gnt=1 in cycle N; the loser's gnt=0, and the loser keeps req/addr stable.
- rom_addr = winner's addr in cycle N. With no request, rom_addr = last_addr_q (last issued address, reset 0); the ROM read in this cycle is discarded.
- prio_q (1 bit, reset 0 = master 0 preferred): on any grant, prio_q <= the other master's index. It is unchanged on idle cycles.
- Pipeline tracking: s1_vld/s1_own registered at the end of cycle N (vld=any grant, own=winner). s2 is captured at the end of N+1 from s1, and rom_dout is sampled into the owner's rd_data register at the same edge.
- mX_rdy = s2_vld & (s2_own==X), asserted during cycle N+2. mX_rd_data is updated only at that capture. The other master's rd_data is untouched.
- No backpressure on return: masters must accept rdy when it arrives. Up to 2 reads are in flight; ordering per master is preserved (in-order, single ROM).
- No read may be dropped or duplicated: exactly one rdy per gnt, to the same master.

## Timing
- Grant-to-data latency: gnt in cycle N, then rdy and rd_data valid in cycle N+2.
- Throughput: 1 grant per cycle total. Under continuous contention with ROUND_ROBIN=1, grants alternate m0, m1, m0, … starting with m0 after reset.
- Back-to-back from one master: a master holding req=1 with no competitor is granted every cycle. Its rdy is then high for consecutive cycles, with rd_data changing each cycle.
- Reset (reset_n low, asynchronous): m0_gnt=m1_gnt=0 (forced while in reset), m0_rdy=m1_rdy=0, m0_rd_data=m1_rd_data=0, rom_addr=0, prio_q=0, s1_vld=s2_vld=0, last_addr_q=0.
- Reset mid-operation clears all in-flight reads: no rdy is emitted for grants issued before reset, and masters must reissue.
- After reset_n rises, the first rising edge may grant.
- Simultaneous events: a new grant, an s1→s2 shift and an rd_data capture all occur on the same edge without interference.

## Test plan
- Single read: ROM[0x005]=0x12345678. Pulse m0_req with m0_addr=0x005 -> m0_gnt in cycle N; m0_rdy=1 with m0_rd_data=0x12345678 in N+2 only; m1_rdy stays 0.
- Contention, round-robin: m0 and m1 request continuously (addrs 0x001/0x002, ROM=0xA1/0xA2) -> grants m0,m1,m0,m1; rdy alternates 2 cycles later with the matching data; no grant is lost.
- Fixed priority (ROUND_ROBIN=0): both request for 4 cycles -> m0_gnt=1 every cycle, m1_gnt=0 throughout; m1 is granted the cycle after m0_req drops.
- Streaming: m1 reads addresses 0..7 back-to-back -> 8 consecutive m1_rdy pulses carrying ROM[0]..ROM[7] in order; m0_rd_data holds its previous value.
- Reset mid-flight: grant m0 in cycle N and assert reset_n=0 in N+1 -> no m0_rdy; all outputs 0 immediately; after release, prio_q favours m0.
- Idle: no requests for 10 cycles -> rom_addr holds the last issued address, and no rdy pulses occur.

Source files
------------

// File: rtl/rom_arbiter_if.sv
// Read-master port of the ROM arbiter: request/address in, grant/ready/data back.
// The master modport is the requester side; slave is the arbiter side.
interface rom_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) ();
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              gnt;
    logic              rdy;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rdy,
        input  rd_data
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rdy,
        output rd_data
    );
endinterface

// File: rtl/rom_arbiter.sv
// Purpose: shares one single-port synchronous-read ROM between two read masters.
// Latency: gnt in cycle N, rdy + rd_data in cycle N+2; one grant per cycle total.
// Backpressure: none on return; a losing requester holds req/addr until granted.
module rom_arbiter #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 32,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    rom_arbiter_if.slave      m0,
    rom_arbiter_if.slave      m1,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout
);
    typedef struct packed {
        logic vld;
        logic own;
    } stage_t;

    logic              prio_q, prio_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    stage_t            s1_q, s1_d;
    stage_t            s2_q, s2_d;
    logic [DATA_W-1:0] rd0_q, rd0_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;

    logic              win_vld;
    logic              win_own;
    logic [ADDR_W-1:0] win_addr;

    // Grants are suppressed while reset is held so nothing escapes to a master.
    always_comb begin
        win_vld = 1'b0;
        win_own = 1'b0;
        if (reset_n) begin
            unique case ({m1.req, m0.req})
                2'b01: begin
                    win_vld = 1'b1;
                    win_own = 1'b0;
                end
                2'b10: begin
                    win_vld = 1'b1;
                    win_own = 1'b1;
                end
                2'b11: begin
                    win_vld = 1'b1;
                    win_own = ROUND_ROBIN ? prio_q : 1'b0;
                end
                default: begin
                    win_vld = 1'b0;
                    win_own = 1'b0;
                end
            endcase
        end
    end

    assign win_addr = win_own ? m1.addr : m0.addr;

    always_comb begin
        prio_d      = win_vld ? ~win_own : prio_q;
        last_addr_d = win_vld ? win_addr : last_addr_q;
        s1_d        = '{vld: win_vld, own: win_own};
        s2_d        = s1_q;
        // ROM data for the s1 read is on rom_dout now; it lands with the s2 shift.
        rd0_d       = (s1_q.vld && !s1_q.own) ? rom_dout : rd0_q;
        rd1_d       = (s1_q.vld &&  s1_q.own) ? rom_dout : rd1_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q      <= 1'b0;
            last_addr_q <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            rd0_q       <= '0;
            rd1_q       <= '0;
        end else begin
            prio_q      <= prio_d;
            last_addr_q <= last_addr_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            rd0_q       <= rd0_d;
            rd1_q       <= rd1_d;
        end
    end

    assign m0.gnt     = win_vld & ~win_own;
    assign m1.gnt     = win_vld &  win_own;
    assign rom_addr   = win_vld ? win_addr : last_addr_q;

    assign m0.rdy     = s2_q.vld & ~s2_q.own;
    assign m1.rdy     = s2_q.vld &  s2_q.own;
    assign m0.rd_data = rd0_q;
    assign m1.rd_data = rd1_q;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        !(m0.gnt && m1.gnt));

    a_m0_hold: assert property (@(posedge clk) disable iff (!reset_n)
        (m0.req && !m0.gnt) |=> (m0.req && $stable(m0.addr)));

    a_m1_hold: assert property (@(posedge clk) disable iff (!reset_n)
        (m1.req && !m1.gnt) |=> (m1.req && $stable(m1.addr)));

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboarded bench: a round-robin and a fixed-priority arbiter run side by side,
// each with its own ROM model, checked against a queue-based reference model.
module tb_rom_arbiter;
    localparam int AW = 11;
    localparam int DW = 32;

    typedef struct packed {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) rr0 ();
    rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) rr1 ();
    rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) fp0 ();
    rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) fp1 ();

    logic [AW-1:0] rom_addr_rr, rom_addr_fp;
    logic [DW-1:0] rom_dout_rr, rom_dout_fp;

    rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(1'b1)) dut_rr (
        .clk(clk), .reset_n(reset_n), .m0(rr0), .m1(rr1),
        .rom_addr(rom_addr_rr), .rom_dout(rom_dout_rr)
    );

    rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ROUND_ROBIN(1'b0)) dut_fp (
        .clk(clk), .reset_n(reset_n), .m0(fp0), .m1(fp1),
        .rom_addr(rom_addr_fp), .rom_dout(rom_dout_fp)
    );

    logic [DW-1:0] rom_mem [2048];

    always @(posedge clk) begin
        rom_dout_rr <= rom_mem[rom_addr_rr];
        rom_dout_fp <= rom_mem[rom_addr_fp];
    end

    // Index [d][m]: d=0 round-robin DUT, d=1 fixed-priority DUT; m = master.
    logic          req_a  [2][2];
    logic [AW-1:0] addr_a [2][2];
    logic          gnt_a  [2][2];
    logic          rdy_a  [2][2];
    logic [DW-1:0] rd_a   [2][2];
    logic [AW-1:0] raddr_a[2];

    assign rr0.req = req_a[0][0];  assign rr0.addr = addr_a[0][0];
    assign rr1.req = req_a[0][1];  assign rr1.addr = addr_a[0][1];
    assign fp0.req = req_a[1][0];  assign fp0.addr = addr_a[1][0];
    assign fp1.req = req_a[1][1];  assign fp1.addr = addr_a[1][1];

    assign gnt_a[0][0] = rr0.gnt;  assign rdy_a[0][0] = rr0.rdy;  assign rd_a[0][0] = rr0.rd_data;
    assign gnt_a[0][1] = rr1.gnt;  assign rdy_a[0][1] = rr1.rdy;  assign rd_a[0][1] = rr1.rd_data;
    assign gnt_a[1][0] = fp0.gnt;  assign rdy_a[1][0] = fp0.rdy;  assign rd_a[1][0] = fp0.rd_data;
    assign gnt_a[1][1] = fp1.gnt;  assign rdy_a[1][1] = fp1.rdy;  assign rd_a[1][1] = fp1.rd_data;
    assign raddr_a[0]  = rom_addr_rr;
    assign raddr_a[1]  = rom_addr_fp;

    // Reference model state
    logic [AW-1:0] src_q  [2][2][$];   // reads each master still wants issued
    exp_t          exp_q  [2][2][$];   // granted reads awaiting their rdy
    logic [DW-1:0] last_data[2][2] = '{'{32'h0, 32'h0}, '{32'h0, 32'h0}};
    logic [AW-1:0] last_addr[2]    = '{11'h0, 11'h0};
    bit            last_g[2]       = '{1'b1, 1'b1};
    bit            grant_log[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit busy();
        bit b = 1'b0;
        for (int d = 0; d < 2; d++)
            for (int m = 0; m < 2; m++)
                if (src_q[d][m].size() != 0 || exp_q[d][m].size() != 0) b = 1'b1;
        return b;
    endfunction

    // One clock cycle: drive at +1, check grants/rom_addr at +4.
    task automatic step(input bit rst_val);
        bit            w_vld;
        bit            w;
        logic [AW-1:0] a;
        @(posedge clk);
        #1;
        reset_n = rst_val;
        for (int d = 0; d < 2; d++)
            for (int m = 0; m < 2; m++) begin
                req_a[d][m]  = (src_q[d][m].size() != 0);
                addr_a[d][m] = req_a[d][m] ? src_q[d][m][0] : AW'($urandom_range(0, 2047));
            end
        if (!rst_val) begin
            for (int d = 0; d < 2; d++) begin
                for (int m = 0; m < 2; m++) begin
                    exp_q[d][m].delete();
                    last_data[d][m] = '0;
                end
                last_g[d]    = 1'b1;
                last_addr[d] = '0;
            end
        end
        #1;
        if (!rst_val) begin
            for (int d = 0; d < 2; d++)
                for (int m = 0; m < 2; m++) begin
                    chk($sformatf("reset rdy d%0d m%0d", d, m), 64'(rdy_a[d][m]), 64'h0);
                    chk($sformatf("reset rd_data d%0d m%0d", d, m), 64'(rd_a[d][m]), 64'h0);
                end
        end
        #2;
        for (int d = 0; d < 2; d++) begin
            w_vld = 1'b0;
            w     = 1'b0;
            if (rst_val) begin
                if (req_a[d][0] && req_a[d][1]) begin
                    w_vld = 1'b1;
                    w     = (d == 0) ? ~last_g[d] : 1'b0;
                end else if (req_a[d][0]) begin
                    w_vld = 1'b1;
                end else if (req_a[d][1]) begin
                    w_vld = 1'b1;
                    w     = 1'b1;
                end
            end
            chk($sformatf("gnt d%0d m0", d), 64'(gnt_a[d][0]), 64'(w_vld && !w));
            chk($sformatf("gnt d%0d m1", d), 64'(gnt_a[d][1]), 64'(w_vld && w));
            a = w_vld ? addr_a[d][w] : last_addr[d];
            chk($sformatf("rom_addr d%0d", d), 64'(raddr_a[d]), 64'(a));
            if (w_vld) begin
                last_addr[d] = a;
                last_g[d]    = w;
                exp_q[d][w].push_back('{due: cyc + 2, data: rom_mem[a]});
                void'(src_q[d][w].pop_front());
                if (d == 0) grant_log.push_back(w);
            end
        end
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while (busy() && n < max_cycles) begin
            step(1'b1);
            n++;
        end
        chk("drain timeout", 64'(busy()), 64'h0);
    endtask

    // Monitor: rdy must appear exactly when the oldest read for that master is due.
    initial begin
        exp_t e;
        bit   exp_r;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                for (int m = 0; m < 2; m++) begin
                    while (exp_q[d][m].size() != 0 && exp_q[d][m][0].due < cyc)
                        void'(exp_q[d][m].pop_front());
                    exp_r = (exp_q[d][m].size() != 0) && (exp_q[d][m][0].due == cyc);
                    chk($sformatf("rdy d%0d m%0d", d, m), 64'(rdy_a[d][m]), 64'(exp_r));
                    if (exp_r) begin
                        e = exp_q[d][m].pop_front();
                        last_data[d][m] = e.data;
                    end
                    chk($sformatf("rd_data d%0d m%0d", d, m), 64'(rd_a[d][m]), 64'(last_data[d][m]));
                end
        end
    end

    initial begin
        for (int i = 0; i < 2048; i++) rom_mem[i] = $urandom;
        rom_mem[5] = 32'h1234_5678;
        rom_mem[1] = 32'h0000_00A1;
        rom_mem[2] = 32'h0000_00A2;
        for (int d = 0; d < 2; d++)
            for (int m = 0; m < 2; m++) begin
                req_a[d][m]  = 1'b0;
                addr_a[d][m] = '0;
            end

        repeat (3) step(1'b0);

        // Continuous contention straight after reset: RR alternates from m0, FP starves m1.
        for (int d = 0; d < 2; d++)
            repeat (4) begin
                src_q[d][0].push_back(11'h001);
                src_q[d][1].push_back(11'h002);
            end
        grant_log.delete();
        drain(40);
        chk("rr grant count", 64'(grant_log.size()), 64'd8);
        for (int i = 0; i < grant_log.size(); i++)
            chk($sformatf("rr order %0d", i), 64'(grant_log[i]), 64'(i % 2));

        // Single read from master 0.
        for (int d = 0; d < 2; d++) src_q[d][0].push_back(11'h005);
        drain(20);

        // Master 1 streams addresses 0..7 back-to-back.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++) src_q[d][1].push_back(AW'(i));
        drain(30);

        // Idle: rom_addr holds, no rdy.
        repeat (10) step(1'b1);

        // Random traffic.
        repeat (400) begin
            for (int d = 0; d < 2; d++)
                for (int m = 0; m < 2; m++)
                    if ($urandom_range(0, 2) == 0 && src_q[d][m].size() < 3)
                        src_q[d][m].push_back(AW'($urandom_range(0, 2047)));
            step(1'b1);
        end
        drain(100);

        // Reset one cycle after a grant: the read is lost, masters reissue.
        for (int d = 0; d < 2; d++) src_q[d][0].push_back(11'h009);
        step(1'b1);
        for (int d = 0; d < 2; d++) begin
            src_q[d][0].push_back(11'h003);
            src_q[d][1].push_back(11'h004);
        end
        step(1'b0);
        step(1'b0);
        grant_log.delete();
        drain(20);
        chk("post-reset first grant", 64'(grant_log.size() > 0 ? grant_log[0] : 1'b1), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
